regfile_access_arbiter: RTL and testbench
=========================================

REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width.
REQ-002 SHALL have parameter DEPTH, default 5, register index width (2**DEPTH registers).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive core grants after which a waiting debug request wins.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports: clk  input  1  clock; reset  input  1  synchronous active-high reset.
REQ-005 {core,dbg}_req_valid  input  1  request present (one line each prefix; same for REQ-006..REQ-012).
REQ-006 {core,dbg}_req_ready  output  1  request accepted this cycle when high with valid.
REQ-007 {core,dbg}_req_write  input  1  1 = write, 0 = read.
REQ-008 {core,dbg}_req_index  input  DEPTH  register index.
REQ-009 {core,dbg}_req_wdata  input  WIDTH  write data.
REQ-010 {core,dbg}_resp_valid  output  1  response available.
REQ-011 {core,dbg}_resp_ready  input  1  response consumed when high with valid.
REQ-012 {core,dbg}_resp_rdata  output  WIDTH  read data; 0 for writes.
REQ-013 rf_read_enable_1  output  1; rf_read_index_1  output  DEPTH; rf_read_data_1  input  WIDTH (high-Z when enable low).
REQ-014 rf_write_enable  output  1; rf_write_index  output  DEPTH; rf_write_data  output  WIDTH.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-016 In IDLE, SHALL assert exactly one req_ready, to the granted requester only; other ready low; no ready in ACCESS/RESP.
REQ-017 Grant: core if core_req_valid, unless dbg_req_valid and starve counter == STARVE_LIMIT, then debug; debug if only debug valid.
REQ-018 Starve counter SHALL increment on each core grant while dbg_req_valid high, clear on debug grant or when dbg_req_valid low, saturate at STARVE_LIMIT.
REQ-019 On accept (valid&&ready, cycle N) SHALL latch owner, write flag, index, wdata and enter ACCESS at N+1.
REQ-020 In ACCESS (N+1), read: rf_read_enable_1=1, rf_read_index_1=latched index, sample rf_read_data_1 into response register at end of cycle.
REQ-021 In ACCESS, write: rf_write_enable=1, index/data from latch, unless index==0, then rf_write_enable stays 0 (x0 immutable); read of index 0 SHALL return 0 regardless of rf_read_data_1.
REQ-022 All rf_* enables SHALL be 0 outside ACCESS; indices/data 0 outside ACCESS.
REQ-023 ACCESS SHALL always last exactly one cycle then go to RESP; owner's resp_valid high from N+2.
REQ-024 resp_valid and resp_rdata SHALL hold stable until resp_ready; transition to IDLE on the handshake cycle; next accept no earlier than the following cycle.
REQ-025 Requests arriving while busy SHALL wait (ready low); no request dropped or reordered within a requester.
REQ-026 Non-owner resp_valid SHALL be 0 at all times.

Reset
REQ-027 On reset SHALL go to IDLE, clear starve counter, latches and response register; all ready, resp_valid, rf_* outputs 0 in the reset cycle.
REQ-028 Reset during ACCESS SHALL suppress rf_write_enable that cycle (no register write); in-flight transaction discarded, no response issued.

Structure
REQ-029 State encoding (IDLE/ACCESS/RESP) and owner encoding SHALL live in the shared core package alongside WIDTH/DEPTH defaults.
REQ-030 Grant/starvation logic SHALL be one sub-module, regfile_grant_select; datapath latches and FSM stay in the top module.

Verification
REQ-031 Core write idx 5 data 0xDEADBEEF accepted cycle N -> rf_write_enable=1, index 5 at N+1; core_resp_valid at N+2; subsequent core read idx 5 returns 0xDEADBEEF.
REQ-032 Debug write idx 0 data 0x12345678 -> rf_write_enable stays 0; debug read idx 0 returns 0; response still issued.
REQ-033 Core and debug valid continuously -> grants core,core,core,core,debug repeating with STARVE_LIMIT=4.
REQ-034 Core resp_ready held low 10 cycles -> resp_valid/rdata stable 10 cycles, no new req_ready, rf_* idle throughout.
REQ-035 Reset asserted in ACCESS of write idx 7 -> no write; idx 7 reads 0 after reset; no resp_valid.
REQ-036 Random core/debug mix vs. reference register model -> every read matches model, all responses in order per requester.

Source files
------------

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared definitions for the register-file access arbiter: default sizes,
// FSM state encoding and transaction owner encoding.
package regfile_access_arbiter_pkg;

  localparam int DEFAULT_WIDTH        = 32;
  localparam int DEFAULT_DEPTH        = 5;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_DBG  = 1'b1
  } owner_e;

endpackage

// File: rtl/regfile_grant_select.sv
// Core-priority grant selection with a starvation counter that lets a
// waiting debug request win after STARVE_LIMIT consecutive core grants.
module regfile_grant_select
  import regfile_access_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic core_req_valid,
  input  logic dbg_req_valid,
  output logic grant_core,
  output logic grant_dbg
);

  // +2 keeps the counter at least one bit wide even for STARVE_LIMIT == 0
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_reg;
  logic             starved;
  logic             dbg_wins;

  assign starved  = (starve_reg == LIMIT);
  assign dbg_wins = dbg_req_valid && (!core_req_valid || starved);

  // Exactly one grant while enabled; core is the default owner of ready
  assign grant_dbg  = enable && dbg_wins;
  assign grant_core = enable && !dbg_wins;

  // Count core grants taken while debug waits; clear when debug is served or leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= '0;
    end else if (!dbg_req_valid || grant_dbg) begin
      starve_reg <= '0;
    end else if (grant_core && core_req_valid && !starved) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Arbitrates core and debug access to a single register-file port pair.
// One transaction in flight: IDLE (grant/accept) -> ACCESS (one cycle on the
// register file) -> RESP (held until the owner consumes it).
module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req_valid,
  output logic             core_req_ready,
  input  logic             core_req_write,
  input  logic [DEPTH-1:0] core_req_index,
  input  logic [WIDTH-1:0] core_req_wdata,
  output logic             core_resp_valid,
  input  logic             core_resp_ready,
  output logic [WIDTH-1:0] core_resp_rdata,
  input  logic             dbg_req_valid,
  output logic             dbg_req_ready,
  input  logic             dbg_req_write,
  input  logic [DEPTH-1:0] dbg_req_index,
  input  logic [WIDTH-1:0] dbg_req_wdata,
  output logic             dbg_resp_valid,
  input  logic             dbg_resp_ready,
  output logic [WIDTH-1:0] dbg_resp_rdata,
  output logic             rf_read_enable_1,
  output logic [DEPTH-1:0] rf_read_index_1,
  input  logic [WIDTH-1:0] rf_read_data_1,
  output logic             rf_write_enable,
  output logic [DEPTH-1:0] rf_write_index,
  output logic [WIDTH-1:0] rf_write_data
);

  state_e             state_reg, state_next;
  owner_e             owner_reg;
  logic               write_reg;
  logic [DEPTH-1:0]   index_reg;
  logic [WIDTH-1:0]   wdata_reg;
  logic [WIDTH-1:0]   rdata_reg, rdata_next;

  logic arb_enable;
  logic grant_core, grant_dbg;
  logic accept_core, accept_dbg, accept_any;
  logic index_nonzero;

  // Arbitration only runs in IDLE; reset silences every ready
  assign arb_enable    = (state_reg == ST_IDLE) && !reset;
  assign accept_core   = grant_core && core_req_valid;
  assign accept_dbg    = grant_dbg && dbg_req_valid;
  assign accept_any    = accept_core || accept_dbg;
  // Register 0 is hard-wired: never written, always reads as zero
  assign index_nonzero = (index_reg != '0);

  regfile_grant_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_select (
    .clk           (clk),
    .reset         (reset),
    .enable        (arb_enable),
    .core_req_valid(core_req_valid),
    .dbg_req_valid (dbg_req_valid),
    .grant_core    (grant_core),
    .grant_dbg     (grant_dbg)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, handshakes, register-file strobes and response capture
  always_comb begin
    state_next       = state_reg;
    rdata_next       = rdata_reg;
    core_req_ready   = 1'b0;
    dbg_req_ready    = 1'b0;
    core_resp_valid  = 1'b0;
    dbg_resp_valid   = 1'b0;
    core_resp_rdata  = '0;
    dbg_resp_rdata   = '0;
    rf_read_enable_1 = 1'b0;
    rf_read_index_1  = '0;
    rf_write_enable  = 1'b0;
    rf_write_index   = '0;
    rf_write_data    = '0;
    case (state_reg)
      ST_IDLE: begin
        core_req_ready = grant_core;
        dbg_req_ready  = grant_dbg;
        if (accept_any) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_RESP;
        if (write_reg) begin
          rdata_next = '0;
          if (index_nonzero && !reset) begin
            rf_write_enable = 1'b1;
            rf_write_index  = index_reg;
            rf_write_data   = wdata_reg;
          end
        end else begin
          rdata_next = index_nonzero ? rf_read_data_1 : '0;
          if (!reset) begin
            rf_read_enable_1 = 1'b1;
            rf_read_index_1  = index_reg;
          end
        end
      end
      ST_RESP: begin
        if (!reset) begin
          if (owner_reg == OWNER_CORE) begin
            core_resp_valid = 1'b1;
            core_resp_rdata = rdata_reg;
            if (core_resp_ready) begin
              state_next = ST_IDLE;
            end
          end else begin
            dbg_resp_valid = 1'b1;
            dbg_resp_rdata = rdata_reg;
            if (dbg_resp_ready) begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch on accept and response data register
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg <= OWNER_CORE;
      write_reg <= 1'b0;
      index_reg <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      rdata_reg <= rdata_next;
      if (accept_any) begin
        owner_reg <= accept_dbg ? OWNER_DBG : OWNER_CORE;
        write_reg <= accept_dbg ? dbg_req_write : core_req_write;
        index_reg <= accept_dbg ? dbg_req_index : core_req_index;
        wdata_reg <= accept_dbg ? dbg_req_wdata : core_req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Scoreboard bench for regfile_access_arbiter: requests are issued by tasks
// that push the expected response (from a flat register-array model) when the
// request is accepted; a monitor pops and compares on each response handshake.
module tb_regfile_access_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int NREGS = 1 << DEPTH;
  localparam logic [WIDTH-1:0] BUS_IDLE = 32'hA5A5_5A5A;

  logic             clk = 1'b0;
  logic             reset;
  logic             core_req_valid, core_req_ready, core_req_write;
  logic [DEPTH-1:0] core_req_index;
  logic [WIDTH-1:0] core_req_wdata;
  logic             core_resp_valid, core_resp_ready;
  logic [WIDTH-1:0] core_resp_rdata;
  logic             dbg_req_valid, dbg_req_ready, dbg_req_write;
  logic [DEPTH-1:0] dbg_req_index;
  logic [WIDTH-1:0] dbg_req_wdata;
  logic             dbg_resp_valid, dbg_resp_ready;
  logic [WIDTH-1:0] dbg_resp_rdata;
  logic             rf_read_enable_1;
  logic [DEPTH-1:0] rf_read_index_1;
  logic [WIDTH-1:0] rf_read_data_1;
  logic             rf_write_enable;
  logic [DEPTH-1:0] rf_write_index;
  logic [WIDTH-1:0] rf_write_data;

  // Physical register file; x0 holds junk so the arbiter must mask it
  logic [WIDTH-1:0] phys [NREGS] = '{0: 32'hBAD0_BAD0, default: 32'h0};

  // Reference model and scoreboard
  logic [WIDTH-1:0] ref_mem [NREGS];
  logic [WIDTH-1:0] exp_core [$];
  logic [WIDTH-1:0] exp_dbg [$];
  bit               grant_log [$];
  int               checks = 0;
  int               failures = 0;
  bit               core_done, dbg_done;

  always #5 clk = ~clk;

  regfile_access_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_write  (core_req_write),
    .core_req_index  (core_req_index),
    .core_req_wdata  (core_req_wdata),
    .core_resp_valid (core_resp_valid),
    .core_resp_ready (core_resp_ready),
    .core_resp_rdata (core_resp_rdata),
    .dbg_req_valid   (dbg_req_valid),
    .dbg_req_ready   (dbg_req_ready),
    .dbg_req_write   (dbg_req_write),
    .dbg_req_index   (dbg_req_index),
    .dbg_req_wdata   (dbg_req_wdata),
    .dbg_resp_valid  (dbg_resp_valid),
    .dbg_resp_ready  (dbg_resp_ready),
    .dbg_resp_rdata  (dbg_resp_rdata),
    .rf_read_enable_1(rf_read_enable_1),
    .rf_read_index_1 (rf_read_index_1),
    .rf_read_data_1  (rf_read_data_1),
    .rf_write_enable (rf_write_enable),
    .rf_write_index  (rf_write_index),
    .rf_write_data   (rf_write_data)
  );

  // Register file behaviour; an unenabled read port shows a junk pattern
  assign rf_read_data_1 = rf_read_enable_1 ? phys[rf_read_index_1] : BUS_IDLE;
  always @(posedge clk) begin
    if (rf_write_enable) phys[rf_write_index] <= rf_write_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted; push its expected response
  task automatic issue(input bit is_dbg, input bit wr, input logic [DEPTH-1:0] idx,
                       input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] exp_val;
    bit done;
    done = 1'b0;
    if (is_dbg) begin
      dbg_req_valid = 1'b1; dbg_req_write = wr; dbg_req_index = idx; dbg_req_wdata = wd;
    end else begin
      core_req_valid = 1'b1; core_req_write = wr; core_req_index = idx; core_req_wdata = wd;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (!reset && (is_dbg ? dbg_req_ready : core_req_ready)) begin
        exp_val = (wr || idx == 0) ? '0 : ref_mem[idx];
        if (wr && idx != 0) ref_mem[idx] = wd;
        if (is_dbg) exp_dbg.push_back(exp_val);
        else        exp_core.push_back(exp_val);
        grant_log.push_back(is_dbg);
        done = 1'b1;
        $display("issue %s %s idx=%0d wdata=0x%08h expect=0x%08h",
                 is_dbg ? "dbg " : "core", wr ? "W" : "R", idx, wd, exp_val);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=not accepted required=accepted", is_dbg ? "dbg" : "core");
    end
    align();
    if (is_dbg) dbg_req_valid = 1'b0;
    else        core_req_valid = 1'b0;
  endtask

  // Wait until every issued request has been answered and consumed
  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 500 && !idle; c++) begin
      @(negedge clk);
      #1;
      idle = (exp_core.size() == 0) && (exp_dbg.size() == 0) && !core_req_valid && !dbg_req_valid;
    end
    if (!idle) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=core_q=%0d dbg_q=%0d required=empty", exp_core.size(), exp_dbg.size());
    end
    align();
  endtask

  // Response monitor: pops the scoreboard on every response handshake
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (core_req_ready || dbg_req_ready)
          check("req_ready_exclusive", 64'(core_req_ready && dbg_req_ready), 64'd0);
        if (core_resp_valid || dbg_resp_valid)
          check("resp_valid_exclusive", 64'(core_resp_valid && dbg_resp_valid), 64'd0);
        if (core_resp_valid && core_resp_ready) begin
          if (exp_core.size() == 0) begin
            checks++; failures++;
            $display("FAIL core_resp_unexpected actual=resp rdata=0x%0h required=no response", core_resp_rdata);
          end else begin
            e = exp_core.pop_front();
            check("core_resp_rdata", 64'(core_resp_rdata), 64'(e));
            $display("resp core rdata=0x%08h expect=0x%08h", core_resp_rdata, e);
          end
        end
        if (dbg_resp_valid && dbg_resp_ready) begin
          if (exp_dbg.size() == 0) begin
            checks++; failures++;
            $display("FAIL dbg_resp_unexpected actual=resp rdata=0x%0h required=no response", dbg_resp_rdata);
          end else begin
            e = exp_dbg.pop_front();
            check("dbg_resp_rdata", 64'(dbg_resp_rdata), 64'(e));
            $display("resp dbg  rdata=0x%08h expect=0x%08h", dbg_resp_rdata, e);
          end
        end
      end
    end
  end

  // Hard stop in case something wedges outside every bounded wait
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] old7;
    for (int i = 0; i < NREGS; i++) ref_mem[i] = '0;
    reset = 1'b1;
    core_req_valid = 1'b1; core_req_write = 1'b1; core_req_index = 5'd3; core_req_wdata = 32'h1111_1111;
    dbg_req_valid  = 1'b1; dbg_req_write  = 1'b1; dbg_req_index  = 5'd4; dbg_req_wdata  = 32'h2222_2222;
    core_resp_ready = 1'b1; dbg_resp_ready = 1'b1;
    core_done = 1'b0; dbg_done = 1'b0;

    // Reset: everything quiet even with requests pending
    repeat (3) begin
      @(negedge clk);
      check("rst_core_req_ready", 64'(core_req_ready), 64'd0);
      check("rst_dbg_req_ready", 64'(dbg_req_ready), 64'd0);
      check("rst_resp_valid", 64'({core_resp_valid, dbg_resp_valid}), 64'd0);
      check("rst_rf_enables", 64'({rf_read_enable_1, rf_write_enable}), 64'd0);
      check("rst_rf_index_data", 64'({rf_read_index_1, rf_write_index, rf_write_data}), 64'd0);
    end
    align();
    reset = 1'b0; core_req_valid = 1'b0; dbg_req_valid = 1'b0;
    align();

    // Core write to x5: write strobe one cycle after accept, response one later
    issue(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    check("w5_rf_write_enable", 64'(rf_write_enable), 64'd1);
    check("w5_rf_write_index", 64'(rf_write_index), 64'd5);
    check("w5_rf_write_data", 64'(rf_write_data), 64'hDEAD_BEEF);
    check("w5_resp_early", 64'(core_resp_valid), 64'd0);
    align();
    check("w5_resp_valid", 64'(core_resp_valid), 64'd1);
    check("w5_resp_rdata", 64'(core_resp_rdata), 64'd0);
    check("w5_rf_idle_in_resp", 64'(rf_write_enable), 64'd0);
    drain();
    issue(1'b0, 1'b0, 5'd5, 32'h0);
    drain();

    // Debug write to x0 never reaches the file; x0 reads back as zero
    issue(1'b1, 1'b1, 5'd0, 32'h1234_5678);
    check("x0_rf_write_enable", 64'(rf_write_enable), 64'd0);
    drain();
    issue(1'b1, 1'b0, 5'd0, 32'h0);
    drain();

    // Stalled core response: stable, no grants, register file idle
    core_resp_ready = 1'b0;
    issue(1'b0, 1'b0, 5'd5, 32'h0);
    check("stall_rf_read_enable", 64'(rf_read_enable_1), 64'd1);
    check("stall_rf_read_index", 64'(rf_read_index_1), 64'd5);
    fork
      issue(1'b1, 1'b0, 5'd3, 32'h0);
    join_none
    align();
    for (int k = 0; k < 10; k++) begin
      check("stall_resp_valid", 64'(core_resp_valid), 64'd1);
      check("stall_resp_rdata", 64'(core_resp_rdata), 64'hDEAD_BEEF);
      check("stall_req_ready", 64'({core_req_ready, dbg_req_ready}), 64'd0);
      check("stall_dbg_resp", 64'(dbg_resp_valid), 64'd0);
      check("stall_rf_idle", 64'({rf_read_enable_1, rf_write_enable, rf_read_index_1, rf_write_index, rf_write_data}), 64'd0);
      align();
    end
    core_resp_ready = 1'b1;
    drain();

    // Both requesters always pending: four core grants, then one debug
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) issue(1'b0, 1'b0, 5'(i + 1), 32'h0);
      end
      begin
        for (int i = 0; i < 2; i++) issue(1'b1, 1'b0, 5'(i + 10), 32'h0);
      end
    join
    drain();
    check("starve_grant_count", 64'(grant_log.size()), 64'd10);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      check($sformatf("starve_grant_%0d", k), 64'(grant_log[k]), 64'((k % 5) == 4));

    // Reset in the ACCESS cycle of a write to x7 aborts it completely
    old7 = ref_mem[7];
    issue(1'b0, 1'b1, 5'd7, 32'hCAFE_F00D);
    reset = 1'b1;
    @(negedge clk);
    check("rst_access_write_enable", 64'(rf_write_enable), 64'd0);
    check("rst_access_resp_valid", 64'(core_resp_valid), 64'd0);
    align();
    reset = 1'b0;
    ref_mem[7] = old7;
    exp_core.delete();
    exp_dbg.delete();
    repeat (3) begin
      @(negedge clk);
      check("post_rst_resp_valid", 64'({core_resp_valid, dbg_resp_valid}), 64'd0);
    end
    align();
    issue(1'b0, 1'b0, 5'd7, 32'h0);
    drain();

    // Random mix of both requesters with random response back-pressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) align();
          issue(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, NREGS - 1)), $urandom());
        end
        core_done = 1'b1;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 4)) align();
          issue(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, NREGS - 1)), $urandom());
        end
        dbg_done = 1'b1;
      end
      begin
        while (!(core_done && dbg_done)) begin
          align();
          core_resp_ready = ($urandom_range(0, 3) != 0);
          dbg_resp_ready  = ($urandom_range(0, 3) != 0);
        end
        core_resp_ready = 1'b1;
        dbg_resp_ready  = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
